// File: rtl/mux_rr_reg.sv
// Registered N-way word multiplexer with direct-select and round-robin modes.
// One output register with a valid/ready handshake on both sides.
module mux_rr_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_ch
);

  logic [SEL_W-1:0]    rr_ptr;
  logic                load_en;
  logic [CHANNELS-1:0] direct_hit;
  logic                direct_valid;
  logic                rr_valid;
  logic [SEL_W-1:0]    rr_idx;
  logic                grant_valid;
  logic [SEL_W-1:0]    grant_idx;

  // (base + offs) mod CHANNELS, with base < CHANNELS and offs < CHANNELS
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= CHANNELS) s = s - CHANNELS;
    return SEL_W'(s);
  endfunction

  assign load_en = !out_valid || out_ready;

  // Comparing sel against each real index means sel >= CHANNELS simply never hits.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign direct_hit[gi] = in_valid[gi] && (sel == SEL_W'(gi));
      assign in_ready[gi]   = rst_n && grant_valid && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  assign direct_valid = |direct_hit;

  // Scan from the far end back toward rr_ptr so the last hit written is the first in order.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (in_valid[wrap_add(rr_ptr, k)]) begin
        rr_valid = 1'b1;
        rr_idx   = wrap_add(rr_ptr, k);
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (load_en) begin
      if (mode) begin
        grant_valid = rr_valid;
        grant_idx   = rr_idx;
      end else begin
        grant_valid = direct_valid;
        grant_idx   = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (grant_valid) begin
      out       <= in_data[grant_idx*WIDTH +: WIDTH];
      out_ch    <= grant_idx;
      out_valid <= 1'b1;
      if (mode) begin
        rr_ptr <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Self-checking bench for mux_rr_reg: 8-channel table run with a scoreboard,
// plus hand sequences for backpressure, async reset and a 5-channel instance.
module tb_mux_rr_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rst_n5;
  logic [127:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic [2:0]   sel;
  logic         mode;
  logic [15:0]  out;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_ch;

  logic [4:0]   in_ready5;
  logic [15:0]  out5;
  logic         out_valid5;
  logic [2:0]   out_ch5;

  always #5 clk = ~clk;

  mux_rr_reg u8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  mux_rr_reg #(.WIDTH(16), .CHANNELS(5)) u5 (
    .clk(clk), .rst_n(rst_n5), .in_data(in_data[79:0]), .in_valid(in_valid[4:0]),
    .in_ready(in_ready5), .sel(sel), .mode(mode), .out(out5),
    .out_valid(out_valid5), .out_ready(out_ready), .out_ch(out_ch5)
  );

  typedef struct packed {
    logic       m;
    logic [2:0] s;
    logic [7:0] iv;
    logic       o;
    logic [7:0] ir;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  ch;
  } exp_t;

  vec_t tbl [0:20];
  exp_t sb_q [$];
  logic exp_valid;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Entered at posedge+1; samples at posedge+3 and returns at the next posedge+1.
  task automatic step(input logic m, input logic [2:0] s, input logic [7:0] iv,
                      input logic o, input logic [7:0] ir, input string name);
    exp_t e;
    int   ch;
    mode = m; sel = s; in_valid = iv; out_ready = o;
    #2;
    chk({name, ".in_ready"}, {24'd0, in_ready}, {24'd0, ir});
    chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    if (exp_valid && o) begin
      if (sb_q.size() == 0) begin
        chk({name, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk({name, ".out"}, {16'd0, out}, {16'd0, e.data});
        chk({name, ".out_ch"}, {29'd0, out_ch}, {29'd0, e.ch});
      end
    end
    if (ir != 8'd0) begin
      ch = 0;
      for (int i = 0; i < 8; i++) if (ir[i]) ch = i;
      e.data = in_data[ch*16 +: 16];
      e.ch   = 3'(ch);
      sb_q.push_back(e);
    end
    $display("step %-14s mode=%0d sel=%0d iv=%02h ordy=%0d in_ready=%02h out=%04h ch=%0d v=%0d",
             name, m, s, iv, o, in_ready, out, out_ch, out_valid);
    exp_valid = (ir != 8'd0) || (exp_valid && !o);
    @(posedge clk); #1;
  endtask

  task automatic step5(input logic m, input logic [2:0] s, input logic [7:0] iv,
                       input logic [4:0] ir, input string name);
    mode = m; sel = s; in_valid = iv; out_ready = 1'b1;
    #2;
    chk({name, ".in_ready5"}, {27'd0, in_ready5}, {27'd0, ir});
    $display("step5 %-12s mode=%0d sel=%0d iv=%02h in_ready=%02h out=%04h ch=%0d v=%0d",
             name, m, s, iv[4:0], in_ready5, out5, out_ch5, out_valid5);
    @(posedge clk); #1;
  endtask

  initial begin
    //          mode  sel   in_valid ordy  exp in_ready
    tbl[0]  = {1'b1, 3'd0, 8'hFF, 1'b1, 8'h01};
    tbl[1]  = {1'b1, 3'd0, 8'hA5, 1'b1, 8'h04};
    tbl[2]  = {1'b1, 3'd0, 8'hA5, 1'b1, 8'h20};
    tbl[3]  = {1'b1, 3'd0, 8'hA5, 1'b1, 8'h80};
    tbl[4]  = {1'b1, 3'd0, 8'hA5, 1'b1, 8'h01};
    tbl[5]  = {1'b1, 3'd0, 8'hA5, 1'b1, 8'h04};
    tbl[6]  = {1'b0, 3'd5, 8'hFF, 1'b1, 8'h20};
    tbl[7]  = {1'b0, 3'd5, 8'hDF, 1'b1, 8'h00};
    tbl[8]  = {1'b0, 3'd5, 8'hDF, 1'b1, 8'h00};
    tbl[9]  = {1'b0, 3'd3, 8'h08, 1'b0, 8'h08};
    tbl[10] = {1'b1, 3'd0, 8'hFF, 1'b0, 8'h00};
    tbl[11] = {1'b1, 3'd0, 8'hFF, 1'b0, 8'h00};
    tbl[12] = {1'b1, 3'd0, 8'hFF, 1'b0, 8'h00};
    tbl[13] = {1'b1, 3'd0, 8'hFF, 1'b1, 8'h08};
    tbl[14] = {1'b1, 3'd0, 8'h00, 1'b1, 8'h00};
    tbl[15] = {1'b1, 3'd0, 8'h00, 1'b1, 8'h00};
    tbl[16] = {1'b0, 3'd1, 8'h02, 1'b1, 8'h02};
    tbl[17] = {1'b1, 3'd0, 8'h13, 1'b1, 8'h10};
    tbl[18] = {1'b1, 3'd0, 8'h13, 1'b1, 8'h01};
    tbl[19] = {1'b1, 3'd0, 8'h00, 1'b1, 8'h00};
    tbl[20] = {1'b1, 3'd0, 8'h00, 1'b1, 8'h00};

    for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = 16'hC05A | 16'(i << 8);
    in_data[5*16 +: 16] = 16'hBEEF;
    exp_valid = 1'b0;

    // Reset held with every channel requesting
    rst_n = 1'b0; rst_n5 = 1'b0;
    mode = 1'b1; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst.out", {16'd0, out}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_ch", {29'd0, out_ch}, 32'd0);
    chk("rst.in_ready", {24'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++)
      step(tbl[i].m, tbl[i].s, tbl[i].iv, tbl[i].o, tbl[i].ir, $sformatf("row%0d", i));

    // Backpressure: hold 1234 for three cycles, then drain and reload on one edge
    in_data[2*16 +: 16] = 16'h1234;
    step(1'b0, 3'd2, 8'h04, 1'b1, 8'h04, "bp_load");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, "bp_stall");
      chk("bp_stall.out", {16'd0, out}, 32'h1234);
    end
    in_data[2*16 +: 16] = 16'h5678;
    step(1'b0, 3'd2, 8'h04, 1'b1, 8'h04, "bp_release");
    chk("bp_release.out", {16'd0, out}, 32'h5678);
    step(1'b0, 3'd2, 8'h00, 1'b1, 8'h00, "bp_drain");
    step(1'b0, 3'd2, 8'h00, 1'b1, 8'h00, "bp_idle");

    // Asynchronous reset mid-operation, rr_ptr left at 3
    step(1'b1, 3'd0, 8'h04, 1'b1, 8'h04, "rr_to3");
    step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, "pre_rst");
    #3 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.out", {16'd0, out}, 32'd0);
    chk("midrst.out_ch", {29'd0, out_ch}, 32'd0);
    chk("midrst.in_ready", {24'd0, in_ready}, 32'd0);
    sb_q.delete();
    exp_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, "rst_restart");
    chk("rst_restart.out_ch", {29'd0, out_ch}, 32'd0);

    // Five-channel instance: out-of-range sel and pointer wrap
    rst_n5 = 1'b1;
    step5(1'b0, 3'd6, 8'h1F, 5'h00, "c5_sel6");
    step5(1'b0, 3'd7, 8'h1F, 5'h00, "c5_sel7");
    chk("c5.idle_valid", {31'd0, out_valid5}, 32'd0);
    step5(1'b1, 3'd0, 8'h10, 5'h10, "c5_ch4");
    chk("c5_ch4.out_ch", {29'd0, out_ch5}, 32'd4);
    chk("c5_ch4.out", {16'd0, out5}, {16'd0, in_data[4*16 +: 16]});
    chk("c5_ch4.out_valid", {31'd0, out_valid5}, 32'd1);
    step5(1'b1, 3'd0, 8'h11, 5'h01, "c5_wrap");
    chk("c5_wrap.out_ch", {29'd0, out_ch5}, 32'd0);
    step5(1'b1, 3'd0, 8'h00, 5'h00, "c5_idle");
    chk("c5_idle.out_valid", {31'd0, out_valid5}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised, registered N-way word multiplexer; successor to the 16-bit 2/4/8-way combinational mux family.
- Selects one of CHANNELS input streams of WIDTH bits each, under one of two modes:
  - direct select via sel;
  - fair round-robin arbitration.
- Result lands in a single output register with a valid/ready handshake.
- Sits between multiple producers (e.g. register-file read ports, I/O sources) and one consumer.

Parameters:
- WIDTH, 16, data bits per channel (>=1)
- CHANNELS, 8, number of input channels (>=2; need not be a power of two)
- SEL_W, $clog2(CHANNELS), width of sel/out_ch (derived; not overridden)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  channel i has a word pending
- in_ready  output  CHANNELS  channel i word accepted this cycle when in_valid[i] & in_ready[i]
- sel  input  SEL_W  channel index used in mode 0
- mode  input  1  0 = direct select, 1 = round-robin
- out  output  WIDTH  registered output word
- out_valid  output  1  out holds a word not yet consumed
- out_ready  input  1  consumer accepts out this cycle when out_valid & out_ready
- out_ch  output  SEL_W  index of the channel that supplied out

Behaviour:
- Reset (rst_n low, asynchronous, immediate): out=0, out_valid=0, out_ch=0, rr_ptr=0.
  - in_ready is all-zero while rst_n is low.
  - Any word held in the output register is discarded.
  - Reset takes effect regardless of handshake state.
- load_en = !out_valid | out_ready.
  - Register may load when empty or being drained in the same cycle.
  - This allows full throughput of 1 word/cycle.
- Grant decision is combinational each cycle and is made only when load_en=1; otherwise in_ready is all-zero.
  - Mode 0:
    - grant = sel if sel < CHANNELS and in_valid[sel]=1; else no grant.
    - sel >= CHANNELS (non-power-of-two CHANNELS) never grants.
  - Mode 1:
    - Scan channels starting at rr_ptr, ascending, wrapping CHANNELS-1 -> 0.
    - grant = first i with in_valid[i]=1; no valid channel means no grant.
- in_ready[g] = 1 only for the granted channel g; all other bits 0.
  - At most one bit is set per cycle.
- On a rising edge with a grant:
  - out <= in_data[g], out_ch <= g, out_valid <= 1.
  - If mode=1: rr_ptr <= (g+1) mod CHANNELS.
  - Latency is 1 cycle from accept to out_valid.
- On a rising edge without a grant:
  - If out_ready & out_valid: out_valid <= 0. out and out_ch keep their last values.
  - Else all state holds.
- Stall (out_valid=1, out_ready=0):
  - out, out_ch and out_valid are held stable.
  - No input is accepted.
- rr_ptr changes only on a mode-1 grant.
  - Retained across mode-0 operation and across mode switches.
  - Mode changes take effect on the next grant decision; no flush.
- Simultaneous drain and load: the new word replaces the old in the same edge with no bubble, and out_valid stays 1.
- Combinational paths:
  - out_ready -> in_ready
  - in_valid/sel/mode -> in_ready
- No combinational path from any input to out, out_valid or out_ch.

Test Plan:
1. Reset/idle: hold rst_n=0 with all in_valid=1 -> out=0, out_valid=0, out_ch=0, in_ready=0. Release rst_n with out_ready=1, mode=1 -> first accept is ch0, and out_valid=1 one cycle later.
2. Mode 0, WIDTH=16, CHANNELS=8: in_data[ch5]=16'hBEEF, in_valid=8'hFF, sel=5, out_ready=1 -> in_ready=8'h20, and next cycle out=16'hBEEF, out_ch=5. With sel=5 and in_valid[5]=0 -> no grant, and out_valid drops after the drain.
3. Round-robin fairness: mode=1, in_valid=8'b1010_0101, out_ready=1 continuously -> out_ch sequence 0,2,5,7,0,2..., one word per cycle with no bubbles.
4. Backpressure: out_valid=1 with out=16'h1234, out_ready=0 for 3 cycles while inputs are valid -> out stays 16'h1234, in_ready=0 throughout. Raise out_ready -> old word is consumed and the next word is loaded on the same edge.
5. Non-power-of-two (CHANNELS=5): mode=0, sel=6 -> never grants. Mode=1 with rr_ptr after a grant of ch4 -> wraps and grants ch0 next when in_valid=5'b00001.
6. Reset mid-operation: out_valid=1, out_ready=0, mode=1 with rr_ptr=3; assert rst_n=0 between edges -> out_valid=0 and out=0 immediately. After release, round-robin restarts from ch0.
